atm_keypad_frontend: RTL and testbench

Keypad front-end that sits directly upstream of the ATM transaction controller. It scans a 4x4 key matrix, debounces presses, and decodes them. In PIN mode it forwards single digits as DIGITO/DIGITO_STB. In amount mode it accumulates decimal digits into a 32-bit MONTO and issues MONTO_STB on ENTER.

---
 rtl/atm_keypad_frontend_if.sv | 22 ++
 rtl/atm_keypad_frontend.sv | 209 ++++++++++++++++++++
 tb/tb_atm_keypad_frontend.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/atm_keypad_frontend_if.sv
// rtl/atm_keypad_frontend_if.sv - keypad front-end signal bundle
interface atm_keypad_frontend_if;
  logic        HABILITAR;
  logic        MODO_MONTO;
  logic [3:0]  ROW;
  logic [3:0]  COL;
  logic [3:0]  DIGITO;
  logic        DIGITO_STB;
  logic [31:0] MONTO;
  logic        MONTO_STB;
  logic        DESBORDE;

  modport master (
    output HABILITAR, MODO_MONTO, ROW,
    input  COL, DIGITO, DIGITO_STB, MONTO, MONTO_STB, DESBORDE
  );

  modport slave (
    input  HABILITAR, MODO_MONTO, ROW,
    output COL, DIGITO, DIGITO_STB, MONTO, MONTO_STB, DESBORDE
  );
endinterface

// File: rtl/atm_keypad_frontend.sv
// rtl/atm_keypad_frontend.sv - 4x4 keypad scanner, debouncer and PIN/amount decoder
module atm_keypad_frontend #(
  parameter int SCAN_DIV     = 2,
  parameter int DEBOUNCE_CNT = 3,
  parameter int MAX_DIGITS   = 9
) (
  input logic                  Clk,
  input logic                  Reset,
  atm_keypad_frontend_if.slave kp
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam int DW = $clog2(MAX_DIGITS + 1);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_WAIT_REL
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  col_q, col_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic [3:0]  pat_q, pat_d;
  logic [3:0]  code_q, code_d;
  logic [1:0]  row_idx;
  logic        key_evt;
  logic [3:0]  evt_code;

  logic [31:0] acc_q, acc_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic        modo_q, modo_d;
  logic [3:0]  digito_q, digito_d;
  logic        digito_stb_q, digito_stb_d;
  logic [31:0] monto_q, monto_d;
  logic        monto_stb_q, monto_stb_d;
  logic        desborde_q, desborde_d;

  // Lowest active row wins when several rows are high in one column.
  always_comb begin
    row_idx = 2'd0;
    if (kp.ROW[0])      row_idx = 2'd0;
    else if (kp.ROW[1]) row_idx = 2'd1;
    else if (kp.ROW[2]) row_idx = 2'd2;
    else if (kp.ROW[3]) row_idx = 2'd3;
  end

  assign cnt_inc = cnt_q + CW'(1);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= ST_SCAN;
      col_q   <= 2'd0;
      slot_q  <= '0;
      cnt_q   <= '0;
      pat_q   <= 4'd0;
      code_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      slot_q  <= slot_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    slot_d   = slot_q;
    cnt_d    = cnt_q;
    pat_d    = pat_q;
    code_d   = code_q;
    key_evt  = 1'b0;
    evt_code = code_q;
    case (state_q)
      ST_SCAN: begin
        if (slot_q == SW'(SCAN_DIV - 1)) begin
          slot_d = '0;
          if (kp.ROW != 4'd0) begin
            pat_d  = kp.ROW;
            code_d = {row_idx, col_q};
            if (DEBOUNCE_CNT == 1) begin
              key_evt  = 1'b1;
              evt_code = {row_idx, col_q};
              cnt_d    = '0;
              state_d  = ST_WAIT_REL;
            end else begin
              cnt_d   = CW'(1);
              state_d = ST_DEBOUNCE;
            end
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          slot_d = slot_q + SW'(1);
        end
      end
      ST_DEBOUNCE: begin
        if (kp.ROW == pat_q) begin
          if (cnt_inc == CW'(DEBOUNCE_CNT)) begin
            key_evt = 1'b1;
            cnt_d   = '0;
            state_d = ST_WAIT_REL;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          cnt_d   = '0;
          slot_d  = '0;
          col_d   = col_q + 2'd1;
          state_d = ST_SCAN;
        end
      end
      ST_WAIT_REL: begin
        // Any bounce during release restarts the zero-run count.
        if (kp.ROW == 4'd0) begin
          if (cnt_inc == CW'(DEBOUNCE_CNT)) begin
            cnt_d   = '0;
            slot_d  = '0;
            col_d   = col_q + 2'd1;
            state_d = ST_SCAN;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      acc_q        <= 32'd0;
      dcnt_q       <= '0;
      modo_q       <= 1'b0;
      digito_q     <= 4'd0;
      digito_stb_q <= 1'b0;
      monto_q      <= 32'd0;
      monto_stb_q  <= 1'b0;
      desborde_q   <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      dcnt_q       <= dcnt_d;
      modo_q       <= modo_d;
      digito_q     <= digito_d;
      digito_stb_q <= digito_stb_d;
      monto_q      <= monto_d;
      monto_stb_q  <= monto_stb_d;
      desborde_q   <= desborde_d;
    end
  end

  // A mode change clears the entry first; a same-cycle key then sees the cleared state.
  always_comb begin
    acc_d        = acc_q;
    dcnt_d       = dcnt_q;
    modo_d       = kp.MODO_MONTO;
    digito_d     = digito_q;
    digito_stb_d = 1'b0;
    monto_d      = monto_q;
    monto_stb_d  = 1'b0;
    desborde_d   = 1'b0;
    if (kp.MODO_MONTO != modo_q) begin
      acc_d  = 32'd0;
      dcnt_d = '0;
    end
    if (!kp.HABILITAR) begin
      acc_d  = 32'd0;
      dcnt_d = '0;
    end else if (key_evt) begin
      if (!kp.MODO_MONTO) begin
        if (evt_code <= 4'd9) begin
          digito_d     = evt_code;
          digito_stb_d = 1'b1;
        end
      end else if (evt_code <= 4'd9) begin
        if (dcnt_d < DW'(MAX_DIGITS)) begin
          acc_d  = acc_d * 32'd10 + 32'(evt_code);
          dcnt_d = dcnt_d + DW'(1);
        end else begin
          desborde_d = 1'b1;
        end
      end else if (evt_code == 4'd10) begin
        acc_d  = 32'd0;
        dcnt_d = '0;
      end else if (evt_code == 4'd11 && dcnt_d != '0) begin
        monto_d     = acc_d;
        monto_stb_d = 1'b1;
        acc_d       = 32'd0;
        dcnt_d      = '0;
      end
    end
  end

  assign kp.COL        = 4'b0001 << col_q;
  assign kp.DIGITO     = digito_q;
  assign kp.DIGITO_STB = digito_stb_q;
  assign kp.MONTO      = monto_q;
  assign kp.MONTO_STB  = monto_stb_q;
  assign kp.DESBORDE   = desborde_q;

endmodule

// File: tb/tb_atm_keypad_frontend.sv
// tb/tb_atm_keypad_frontend.sv - directed bench for atm_keypad_frontend
module tb_atm_keypad_frontend;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  atm_keypad_frontend_if kp();

  atm_keypad_frontend #(
    .SCAN_DIV(2),
    .DEBOUNCE_CNT(3),
    .MAX_DIGITS(9)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .kp(kp)
  );

  // Key matrix: a held key shows its row only while its column is driven.
  logic       key_down;
  logic [3:0] key_code;
  logic       force_en;
  logic [3:0] rows_force;
  logic [3:0] row_m;

  always_comb begin
    row_m = 4'd0;
    if (key_down && kp.COL[key_code[1:0]]) row_m[key_code[3:2]] = 1'b1;
  end
  assign kp.ROW = force_en ? rows_force : row_m;

  int checks;
  int errors;
  int n_dstb, n_mstb, n_desb;

  typedef struct {
    logic        hab;
    logic        modo;
    logic        press;
    logic [3:0]  code;
    int          dstb;
    int          mstb;
    int          desb;
    logic [3:0]  digito;
    logic [31:0] monto;
  } vec_t;

  vec_t tbl[$];

  task automatic tick();
    @(negedge Clk);
    n_dstb += int'(kp.DIGITO_STB);
    n_mstb += int'(kp.MONTO_STB);
    n_desb += int'(kp.DESBORDE);
  endtask

  task automatic clear_counts();
    n_dstb = 0;
    n_mstb = 0;
    n_desb = 0;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic press(input logic [3:0] code);
    key_code = code;
    key_down = 1'b1;
    repeat (20) tick();
    key_down = 1'b0;
    repeat (15) tick();
  endtask

  task automatic add(input logic h, input logic m, input logic p, input logic [3:0] c,
                     input int ds, input int ms, input int de,
                     input logic [3:0] dg, input logic [31:0] mo);
    vec_t v;
    v.hab = h; v.modo = m; v.press = p; v.code = c;
    v.dstb = ds; v.mstb = ms; v.desb = de; v.digito = dg; v.monto = mo;
    tbl.push_back(v);
  endtask

  initial begin
    bit found;
    checks = 0;
    errors = 0;
    clear_counts();
    key_down = 1'b0;
    key_code = 4'd0;
    force_en = 1'b1;
    rows_force = 4'b1111;
    kp.HABILITAR = 1'b1;
    kp.MODO_MONTO = 1'b0;
    Reset = 1'b0;

    // Reset held two cycles with every row high.
    repeat (2) tick();
    check("rst_col", 32'(kp.COL), 32'd1);
    check("rst_digito", 32'(kp.DIGITO), 32'd0);
    check("rst_dstb", 32'(kp.DIGITO_STB), 32'd0);
    check("rst_monto", kp.MONTO, 32'd0);
    check("rst_mstb", 32'(kp.MONTO_STB), 32'd0);
    check("rst_desb", 32'(kp.DESBORDE), 32'd0);
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post_rst_nostb%0d", i), 32'(kp.DIGITO_STB), 32'd0);
    end
    tick();
    check("post_rst_stb", 32'(kp.DIGITO_STB), 32'd1);
    check("post_rst_digito", 32'(kp.DIGITO), 32'd0);
    check("post_rst_col", 32'(kp.COL), 32'd1);
    tick();
    check("post_rst_stb_off", 32'(kp.DIGITO_STB), 32'd0);
    rows_force = 4'd0;
    repeat (6) tick();
    force_en = 1'b0;
    repeat (4) tick();

    // PIN mode: key 5 held, column frozen until three zero samples.
    clear_counts();
    key_code = 4'd5;
    key_down = 1'b1;
    repeat (20) tick();
    check("pin5_col_held", 32'(kp.COL), 32'b0010);
    check("pin5_dstb", 32'(n_dstb), 32'd1);
    check("pin5_digito", 32'(kp.DIGITO), 32'd5);
    key_down = 1'b0;
    repeat (2) tick();
    check("pin5_col_rel2", 32'(kp.COL), 32'b0010);
    tick();
    check("pin5_col_rel3", 32'(kp.COL), 32'b0100);
    repeat (12) tick();
    check("pin5_dstb_total", 32'(n_dstb), 32'd1);

    // Bounce on key 0: high 2, low 1, high 2, aligned to the start of column 0.
    found = 0;
    for (int i = 0; i < 20 && kp.COL == 4'b0001; i++) tick();
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (kp.COL == 4'b0001) found = 1;
    end
    check("bounce_align", 32'(found), 32'd1);
    clear_counts();
    key_code = 4'd0;
    key_down = 1'b1;
    repeat (2) tick();
    key_down = 1'b0;
    tick();
    check("bounce_col_adv", 32'(kp.COL), 32'b0010);
    key_down = 1'b1;
    repeat (2) tick();
    key_down = 1'b0;
    repeat (15) tick();
    check("bounce_dstb", 32'(n_dstb), 32'd0);
    check("bounce_digito", 32'(kp.DIGITO), 32'd5);

    // hab, modo, press, code, dstb, mstb, desb, DIGITO, MONTO after the row
    add(1, 0, 1, 4'd3,  1, 0, 0, 4'd3, 32'd0);
    add(1, 0, 1, 4'd10, 0, 0, 0, 4'd3, 32'd0);
    add(1, 0, 1, 4'd14, 0, 0, 0, 4'd3, 32'd0);
    add(1, 0, 1, 4'd11, 0, 0, 0, 4'd3, 32'd0);
    add(1, 1, 1, 4'd1,  0, 0, 0, 4'd3, 32'd0);
    add(1, 1, 1, 4'd2,  0, 0, 0, 4'd3, 32'd0);
    add(1, 1, 1, 4'd0,  0, 0, 0, 4'd3, 32'd0);
    add(1, 1, 1, 4'd11, 0, 1, 0, 4'd3, 32'd120);
    add(1, 1, 1, 4'd11, 0, 0, 0, 4'd3, 32'd120);
    for (int i = 0; i < 9; i++) add(1, 1, 1, 4'd9, 0, 0, 0, 4'd3, 32'd120);
    add(1, 1, 1, 4'd9,  0, 0, 1, 4'd3, 32'd120);
    add(1, 1, 1, 4'd11, 0, 1, 0, 4'd3, 32'd999999999);
    add(1, 1, 1, 4'd4,  0, 0, 0, 4'd3, 32'd999999999);
    add(1, 1, 1, 4'd10, 0, 0, 0, 4'd3, 32'd999999999);
    add(1, 1, 1, 4'd7,  0, 0, 0, 4'd3, 32'd999999999);
    add(1, 0, 0, 4'd0,  0, 0, 0, 4'd3, 32'd999999999);
    add(1, 1, 0, 4'd0,  0, 0, 0, 4'd3, 32'd999999999);
    add(1, 1, 1, 4'd11, 0, 0, 0, 4'd3, 32'd999999999);
    add(1, 1, 1, 4'd4,  0, 0, 0, 4'd3, 32'd999999999);
    add(0, 1, 0, 4'd0,  0, 0, 0, 4'd3, 32'd999999999);
    add(1, 1, 0, 4'd0,  0, 0, 0, 4'd3, 32'd999999999);
    add(1, 1, 1, 4'd8,  0, 0, 0, 4'd3, 32'd999999999);
    add(1, 1, 1, 4'd11, 0, 1, 0, 4'd3, 32'd8);
    add(0, 1, 1, 4'd3,  0, 0, 0, 4'd3, 32'd8);
    add(1, 1, 1, 4'd11, 0, 0, 0, 4'd3, 32'd8);
    add(0, 0, 1, 4'd6,  0, 0, 0, 4'd3, 32'd8);
    add(1, 1, 1, 4'd5,  0, 0, 0, 4'd3, 32'd8);
    add(1, 1, 1, 4'd10, 0, 0, 0, 4'd3, 32'd8);
    add(1, 1, 1, 4'd11, 0, 0, 0, 4'd3, 32'd8);

    foreach (tbl[i]) begin
      kp.HABILITAR = tbl[i].hab;
      kp.MODO_MONTO = tbl[i].modo;
      clear_counts();
      if (tbl[i].press) press(tbl[i].code);
      else repeat (5) tick();
      check($sformatf("row%0d_dstb", i), 32'(n_dstb), 32'(tbl[i].dstb));
      check($sformatf("row%0d_mstb", i), 32'(n_mstb), 32'(tbl[i].mstb));
      check($sformatf("row%0d_desb", i), 32'(n_desb), 32'(tbl[i].desb));
      check($sformatf("row%0d_digito", i), 32'(kp.DIGITO), 32'(tbl[i].digito));
      check($sformatf("row%0d_monto", i), kp.MONTO, tbl[i].monto);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
